// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 3-digit 7-segment scanner for BCD digits, with frame-aligned digit commit.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] hundreds_in,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       frame_tick
);

  localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_HUND = 2'd0,
    ST_TENS = 2'd1,
    ST_ONES = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       pend_h_q, pend_t_q, pend_o_q;
  logic [3:0]       pend_h_d, pend_t_d, pend_o_d;
  logic [3:0]       disp_h_q, disp_t_q, disp_o_q;
  logic [3:0]       disp_h_d, disp_t_d, disp_o_d;
  logic [6:0]       seg_q, seg_d;
  logic [2:0]       an_q, an_d;
  logic             tick_q, tick_d;

  logic             adv;
  logic             commit;
  logic             blank_h;
  logic             blank_t;
  logic             blank;
  logic [3:0]       digit;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    pend_h_d = pend_h_q;
    pend_t_d = pend_t_q;
    pend_o_d = pend_o_q;
    disp_h_d = disp_h_q;
    disp_t_d = disp_t_q;
    disp_o_d = disp_o_q;
    an_d     = 3'b111;
    digit    = 4'd0;
    blank    = 1'b0;

    adv    = (div_q == DIV_LAST);
    commit = adv && (state_q == ST_ONES);
    div_d  = adv ? '0 : div_q + DIV_W'(1);

    if (adv) begin
      case (state_q)
        ST_HUND: state_d = ST_TENS;
        ST_TENS: state_d = ST_ONES;
        default: state_d = ST_HUND;
      endcase
    end

    if (load) begin
      pend_h_d = hundreds_in;
      pend_t_d = tens_in;
      pend_o_d = ones_in;
    end

    // A load on the commit edge bypasses pending so it shows in the frame now starting.
    if (commit) begin
      disp_h_d = load ? hundreds_in : pend_h_q;
      disp_t_d = load ? tens_in     : pend_t_q;
      disp_o_d = load ? ones_in     : pend_o_q;
    end

`ifdef LEADING_ZERO_BLANK_EN
    blank_h = (disp_h_q == 4'd0);
    blank_t = blank_h && (disp_t_q == 4'd0);
`else
    blank_h = 1'b0;
    blank_t = 1'b0;
`endif

    case (state_q)
      ST_HUND: begin
        an_d  = 3'b011;
        digit = disp_h_q;
        blank = blank_h;
      end
      ST_TENS: begin
        an_d  = 3'b101;
        digit = disp_t_q;
        blank = blank_t;
      end
      default: begin
        an_d  = 3'b110;
        digit = disp_o_q;
        blank = 1'b0;
      end
    endcase

    seg_d  = blank ? 7'h7F : seg_decode(digit);
    tick_d = (state_q == ST_HUND) && (div_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HUND;
      div_q    <= '0;
      pend_h_q <= 4'd0;
      pend_t_q <= 4'd0;
      pend_o_q <= 4'd0;
      disp_h_q <= 4'd0;
      disp_t_q <= 4'd0;
      disp_o_q <= 4'd0;
      seg_q    <= 7'h7F;
      an_q     <= 3'b111;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      pend_h_q <= pend_h_d;
      pend_t_q <= pend_t_d;
      pend_o_q <= pend_o_d;
      disp_h_q <= disp_h_d;
      disp_t_q <= disp_t_d;
      disp_o_q <= disp_o_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: cycle-accurate reference model plus frame-level vector table.
// Expected blanking follows LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_display_scanner;

  localparam int unsigned N     = 4;
  localparam int unsigned FRAME = 3 * N;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] hundreds_in;
  logic [3:0] tens_in;
  logic [3:0] ones_in;
  logic [6:0] seg;
  logic [2:0] an;
  logic       frame_tick;

  int          passed = 0;
  int          total  = 0;
  int unsigned e;
  logic [3:0]  m_pend [3];
  logic [3:0]  m_disp [3];
  logic [6:0]  lut    [16];

  typedef struct {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic [6:0] exp_h;
    logic [6:0] exp_t;
    logic [6:0] exp_o;
  } vec_t;

  vec_t vecs [6];

  bcd_display_scanner #(.REFRESH_DIV(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .hundreds_in (hundreds_in),
    .tens_in     (tens_in),
    .ones_in     (ones_in),
    .seg         (seg),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (edge %0d): got %h, expected %h", name, e, act, exp);
  endtask

  // Digit position 0=hundreds, 1=tens, 2=ones; pattern from the committed model digits.
  function automatic logic [6:0] ref_seg(input int pos);
    bit blank;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (pos == 0) blank = (m_disp[0] == 4'd0);
    if (pos == 1) blank = (m_disp[0] == 4'd0) && (m_disp[1] == 4'd0);
`endif
    return blank ? 7'h7F : lut[m_disp[pos]];
  endfunction

  task automatic model_reset();
    e = 0;
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 4'd0;
      m_disp[i] = 4'd0;
    end
  endtask

  // One clock: drive inputs, clock, check against the model, then advance the model.
  task automatic step(input logic ld, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    int         pos;
    logic [2:0] an_exp;
    logic [6:0] seg_exp;
    logic       tick_exp;
    load = ld; hundreds_in = h; tens_in = t; ones_in = o;
    @(posedge clk);
    #1;
    e++;
    pos      = int'(((e - 1) / N) % 3);
    an_exp   = (pos == 0) ? 3'b011 : (pos == 1) ? 3'b101 : 3'b110;
    seg_exp  = ref_seg(pos);
    tick_exp = (((e - 1) % FRAME) == 0);
    chk("an", 32'(an), 32'(an_exp));
    chk("seg", 32'(seg), 32'(seg_exp));
    chk("frame_tick", 32'(frame_tick), 32'(tick_exp));
    if (ld) begin
      m_pend[0] = h; m_pend[1] = t; m_pend[2] = o;
    end
    if ((e % FRAME) == 0) begin
      for (int i = 0; i < 3; i++) m_disp[i] = m_pend[i];
    end
    load = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  // Advance to the next frame_tick and record the segments shown for each digit in that frame.
  task automatic capture_frame(output logic [6:0] sh, output logic [6:0] st, output logic [6:0] so);
    int guard;
    guard = 0;
    sh = 7'h00; st = 7'h00; so = 7'h00;
    do begin
      idle();
      guard++;
    end while (frame_tick !== 1'b1 && guard < 2 * FRAME);
    if (frame_tick !== 1'b1) chk("frame_tick_timeout", 32'(frame_tick), 32'd1);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) idle();
      case (an)
        3'b011:  sh = seg;
        3'b101:  st = seg;
        3'b110:  so = seg;
        default: ;
      endcase
    end
  endtask

  logic [6:0] ch, ct, co;
  int         guard;

  initial begin
    lut = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
            7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

`ifdef LEADING_ZERO_BLANK_EN
    vecs[0] = '{4'd0, 4'd0, 4'd7, 7'h7F, 7'h7F, 7'b1111000};
    vecs[1] = '{4'd0, 4'd4, 4'd5, 7'h7F, 7'b0011001, 7'b0010010};
`else
    vecs[0] = '{4'd0, 4'd0, 4'd7, 7'b1000000, 7'b1000000, 7'b1111000};
    vecs[1] = '{4'd0, 4'd4, 4'd5, 7'b1000000, 7'b0011001, 7'b0010010};
`endif
    vecs[2] = '{4'd1, 4'd2, 4'd3, 7'b1111001, 7'b0100100, 7'b0110000};
    vecs[3] = '{4'd8, 4'hC, 4'd6, 7'b0000000, 7'b0111111, 7'b0000010};
    vecs[4] = '{4'hA, 4'd0, 4'd0, 7'b0111111, 7'b1000000, 7'b1000000};
    vecs[5] = '{4'd9, 4'd6, 4'd4, 7'b0010000, 7'b0000010, 7'b0011001};

    rst = 1'b1; load = 1'b0; hundreds_in = 4'd0; tens_in = 4'd0; ones_in = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_seg", 32'(seg), 32'h7F);
    chk("reset_an", 32'(an), 32'b111);
    chk("reset_tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    // Free-running scan of zeros from reset.
    repeat (2 * FRAME + 3) idle();

    // Digit table: load mid-frame, next frame must show the new digits.
    foreach (vecs[k]) begin
      repeat ($urandom_range(0, 5)) idle();
      step(1'b1, vecs[k].h, vecs[k].t, vecs[k].o);
      capture_frame(ch, ct, co);
      chk("vec_hund", 32'(ch), 32'(vecs[k].exp_h));
      chk("vec_tens", 32'(ct), 32'(vecs[k].exp_t));
      chk("vec_ones", 32'(co), 32'(vecs[k].exp_o));
    end

    // Load exactly on the commit edge is shown in the frame starting next cycle.
    guard = 0;
    while ((e % FRAME) != FRAME - 1 && guard < 2 * FRAME) begin idle(); guard++; end
    step(1'b1, 4'd2, 4'd5, 4'd5);
    idle();
    chk("bypass_tick", 32'(frame_tick), 32'd1);
    chk("bypass_hund", 32'(seg), 32'(7'b0100100));
    repeat (N) idle();
    chk("bypass_tens", 32'(seg), 32'(7'b0010010));

    // Back-to-back loads within one frame: the last one wins.
    guard = 0;
    while ((e % FRAME) != 1 && guard < 2 * FRAME) begin idle(); guard++; end
    step(1'b1, 4'd9, 4'd9, 4'd9);
    step(1'b1, 4'd0, 4'd4, 4'd5);
    capture_frame(ch, ct, co);
    chk("b2b_hund", 32'(ch), 32'(vecs[1].exp_h));
    chk("b2b_tens", 32'(ct), 32'(vecs[1].exp_t));
    chk("b2b_ones", 32'(co), 32'(vecs[1].exp_o));

    // Randomized traffic, including invalid digits and loads at arbitrary phases.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-TENS discards an uncommitted load.
    guard = 0;
    while ((e % FRAME) != 1 && guard < 2 * FRAME) begin idle(); guard++; end
    step(1'b1, 4'd7, 4'd7, 4'd7);
    guard = 0;
    while (((e / N) % 3) != 1 && guard < 2 * FRAME) begin idle(); guard++; end
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_an", 32'(an), 32'b111);
    chk("async_rst_tick", 32'(frame_tick), 32'd0);
    @(posedge clk);
    #1;
    chk("held_rst_an", 32'(an), 32'b111);
    rst = 1'b0;
    model_reset();
    repeat (3 * FRAME) idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Downstream consumer of the binary-to-BCD converter's hundreds/tens/ones digits. Drives a time-multiplexed 3-digit, 7-segment display.
- Captures a BCD triple on a load strobe.
- Commits the triple only at a frame boundary, so a digit update never tears mid-scan.
- Scans the digits at a programmable refresh rate.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays lit; legal range >= 1; divider width = max(1, $clog2(REFRESH_DIV)).

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  strobe; captures hundreds_in/tens_in/ones_in this cycle
hundreds_in  input  4  BCD hundreds digit
tens_in  input  4  BCD tens digit
ones_in  input  4  BCD ones digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
an  output  3  digit enables, active-low; an[2]=hundreds, an[1]=tens, an[0]=ones; registered
frame_tick  output  1  one-cycle pulse when a new frame (with freshly committed digits) starts

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values:
  - seg=7'h7F, an=3'b111, frame_tick=0.
  - Divider=0, scan state=HUND.
  - Pending and display digit registers = 0.
- Reset asserted mid-scan aborts immediately to these values; a load in progress is lost.
- Scan FSM states HUND -> TENS -> ONES -> HUND. Each state lasts exactly REFRESH_DIV cycles.
- Divider: counts 0..REFRESH_DIV-1, wraps to 0. State advances on the cycle the divider equals REFRESH_DIV-1. With REFRESH_DIV=1, the state advances every cycle.
- Outputs are registered from the current state, so seg/an lag the state by 1 cycle. First clock after reset release gives an=3'b011 with the hundreds pattern.
- an one-hot-low per state: HUND=3'b011, TENS=3'b101, ONES=3'b110. Never more than one digit enabled.
- Load capture: load=1 writes the three inputs into pending registers on that edge. The last load before a commit wins.
- Commit: on the ONES->HUND transition edge, display <= pending.
- Load on the same cycle as a commit: the new inputs go to both pending and display (bypass), so they are shown in the frame that is starting.
- frame_tick is asserted for exactly 1 cycle, aligned with the first cycle an=3'b011 of each new frame. It fires every frame, whether or not the digits changed.
- Segment decode (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Invalid BCD (10..15): dash, 0111111. No error flag.
- No backpressure: load is accepted every cycle it is high.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined:
  - Hundreds digit == 0 -> seg=7'h7F while its an is active.
  - Tens blanked when hundreds==0 and tens==0.
  - Ones never blanked, so 0 displays as a single "0".
  - An invalid hundreds digit is not blanked.
- Undefined: all three digits always decoded, so 5 displays "005".

Test Plan:
1. REFRESH_DIV=4, rst held then released, no load -> an sequence 011(4 cycles), 101(4), 110(4) repeating; seg=1000000 on every digit; frame_tick every 12 cycles.
2. load with 1/2/3 mid-HUND of frame N -> frame N keeps old digits; from frame N+1: hundreds seg=1111001, tens 0100100, ones 0110000; frame_tick marks the first cycle of N+1.
3. load 2/5/5 on the exact ONES->HUND transition cycle -> shown in the frame starting next cycle (bypass). Back-to-back loads 9/9/9 then 0/4/5 in one frame -> 0/4/5 shown.
4. load tens_in=4'hC -> tens digit seg=0111111 (dash); other digits are decoded normally.
5. With LEADING_ZERO_BLANK_EN, load 0/0/7 -> hundreds and tens seg=7F, ones=1111000. Load 0/4/5 -> hundreds 7F, tens 0011001. Without the macro, 0/0/7 -> 1000000, 1000000, 1111000.
6. Assert rst asynchronously mid-TENS (between clock edges) -> seg=7F, an=111, frame_tick=0 immediately. After release, the scan restarts at HUND showing 0/0/0; the earlier pending load is discarded.
